mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width (fixed at 32 for this block).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width.
REQ-003 SHALL have parameter READ_LATENCY, default 1, RAM read latency in cycles: 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE.
REQ-004 SHALL have port clka, input, 1, single clock; all state updates on the rising edge.
REQ-005 SHALL have port rsta, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_size, input, 2: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as misaligned).
REQ-010 SHALL have port req_unsigned, input, 1, zero-extend loads when 1.
REQ-011 SHALL have port req_addr, input, ADDR_WIDTH+2, byte address.
REQ-012 SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-013 SHALL have port rsp_valid, output, 1, response present.
REQ-014 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid && rsp_ready.
REQ-015 SHALL have port rsp_rdata, output, 32, extended load data; 0 for stores.
REQ-016 SHALL have port rsp_err, output, 1, misaligned or reserved-size request.
REQ-017 SHALL have port ram_addr, output, ADDR_WIDTH, word address to the RAM.
REQ-018 SHALL have port ram_din, output, 32, RAM write data.
REQ-019 SHALL have port ram_we, output, 1, RAM write enable.
REQ-020 SHALL have port ram_regce, output, 1, RAM output-register enable.
REQ-021 SHALL have port ram_dout, input, 32, RAM read data.

Function
REQ-022 SHALL implement FSM states IDLE, RD, WR, RSP, with all outputs driven from registers.
REQ-023 SHALL assert req_ready = 1 only in IDLE, and accept at most one request per acceptance edge T.
REQ-024 SHALL use big-endian byte lanes: offset 0 = bits[31:24], offset 3 = bits[7:0]; halfword offset 0 = bits[31:16].
REQ-025 SHALL treat a request as misaligned when: halfword with addr[0] = 1; word with addr[1:0] != 0; or size 11.
REQ-026 SHALL, on acceptance of a misaligned request, go IDLE->RSP with rsp_err = 1 and rsp_rdata = 0, with no RAM access (ram_we stays 0).
REQ-027 SHALL, on acceptance of an aligned word store, set ram_addr = addr[ADDR_WIDTH+1:2], ram_din = req_wdata, ram_we = 1, and go IDLE->WR.
REQ-028 SHALL, in WR, hold ram_we = 1 for exactly one cycle, then go to RSP.
REQ-029 SHALL, on acceptance of a load or sub-word store, set ram_addr and ram_we = 0, go IDLE->RD, and load the wait counter with READ_LATENCY.
REQ-030 SHALL hold ram_regce = 1 in RD and 0 otherwise.
REQ-031 SHALL sample ram_dout at the READ_LATENCY-th rising edge after T.
REQ-032 SHALL, for a load, select the addressed lane, sign- or zero-extend it into rsp_rdata, and go RD->RSP; rsp_valid is therefore high READ_LATENCY cycles after T.
REQ-033 SHALL, for a sub-word store, replace only the addressed lane of the sampled word with req_wdata[7:0] or [15:0] into ram_din, then RD->WR->RSP; rsp_valid is high READ_LATENCY+1 cycles after T.
REQ-034 SHALL latch all request fields at acceptance; input changes while busy have no effect.
REQ-035 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RSP until rsp_ready = 1, then go to IDLE with rsp_valid = 0 on the next cycle.
REQ-036 SHALL, for a word store, complete the RAM write before rsp_valid rises; a load issued immediately after it returns the new data.
REQ-037 SHALL issue back-to-back requests with at least one IDLE cycle between responses; no pipelining.
REQ-038 SHALL use full ADDR_WIDTH wrap-around: the highest word and address 0 are both legal, with no overflow handling.

Reset
REQ-039 SHALL, while rsta = 1, force state = IDLE, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, ram_we = 0, ram_regce = 0, ram_addr = 0, ram_din = 0, and the counter = 0, asynchronously.
REQ-040 SHALL, on reset assertion mid-operation (RD or WR), drop ram_we immediately and discard the request; any partial sub-word store is not written.
REQ-041 SHALL set req_ready = 1 on the first rising edge after rsta deasserts.

Verification
REQ-042 Word store then load: SW addr 0x008 data 0xDEADBEEF, then LW 0x008 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0; load latency = READ_LATENCY cycles, checked for both READ_LATENCY = 1 and 2.
REQ-043 Byte lanes and extension: word 0x80FF7F01 at 0x010; LB 0x010 -> 0xFFFFFF80; LBU 0x010 -> 0x00000080; LH 0x012 -> 0x00007F01; LHU 0x010 -> 0x000080FF.
REQ-044 Read-modify-write: word 0x11223344 at 0x020; SB 0x021 data 0xAA, then SH 0x022 data 0xBEEF -> LW 0x020 = 0x11AABEEF; exactly one ram_we pulse per store.
REQ-045 Misalignment: LW 0x006, SH 0x003, size 11 -> rsp_err = 1, rsp_rdata = 0, ram_we never asserted, memory unchanged.
REQ-046 Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid -> response stable, req_ready = 0 throughout, IDLE one cycle after rsp_ready = 1.
REQ-047 Reset in RD during SB 0x031 -> ram_we = 0 immediately, original word at 0x030 intact, req_ready = 1 on the first edge after release.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Byte/halfword/word load-store front end for a single-port RAM,
//               with big-endian lanes and read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_regce,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RD   = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;
    localparam logic [1:0] c_ST_RSP  = 2'd3;
    localparam int         c_CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;

    logic [1:0]            r_state, w_state;
    logic [c_CNT_W-1:0]    r_cnt, w_cnt;
    logic                  r_we, w_we;
    logic [1:0]            r_size, w_size;
    logic                  r_uns, w_uns;
    logic [1:0]            r_off, w_off;
    logic [15:0]           r_wdata, w_wdata;

    logic                  w_req_ready, w_rsp_valid, w_rsp_err, w_ram_we, w_ram_regce;
    logic [DATA_WIDTH-1:0] w_rsp_rdata, w_ram_din;
    logic [ADDR_WIDTH-1:0] w_ram_addr;

    logic                  w_misaligned;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_data, w_merged;

    assign w_misaligned = (req_size == 2'b11) ||
                          (req_size == 2'b01 && req_addr[0]) ||
                          (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        case (r_off)
            2'd0:    w_byte = ram_dout[31:24];
            2'd1:    w_byte = ram_dout[23:16];
            2'd2:    w_byte = ram_dout[15:8];
            default: w_byte = ram_dout[7:0];
        endcase
        w_half = r_off[1] ? ram_dout[15:0] : ram_dout[31:16];

        if (r_size == 2'b00)
            w_load_data = {{(DATA_WIDTH-8){w_byte[7] & ~r_uns}}, w_byte};
        else if (r_size == 2'b01)
            w_load_data = {{(DATA_WIDTH-16){w_half[15] & ~r_uns}}, w_half};
        else
            w_load_data = ram_dout;

        w_merged = ram_dout;
        if (r_size == 2'b00) begin
            case (r_off)
                2'd0:    w_merged[31:24] = r_wdata[7:0];
                2'd1:    w_merged[23:16] = r_wdata[7:0];
                2'd2:    w_merged[15:8]  = r_wdata[7:0];
                default: w_merged[7:0]   = r_wdata[7:0];
            endcase
        end else if (r_off[1]) begin
            w_merged[15:0] = r_wdata;
        end else begin
            w_merged[31:16] = r_wdata;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_we        = r_we;
        w_size      = r_size;
        w_uns       = r_uns;
        w_off       = r_off;
        w_wdata     = r_wdata;
        w_req_ready = 1'b0;
        w_rsp_valid = rsp_valid;
        w_rsp_rdata = rsp_rdata;
        w_rsp_err   = rsp_err;
        w_ram_addr  = ram_addr;
        w_ram_din   = ram_din;
        w_ram_we    = 1'b0;
        w_ram_regce = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                w_req_ready = 1'b1;
                if (req_valid && req_ready) begin
                    w_req_ready = 1'b0;
                    w_we        = req_we;
                    w_size      = req_size;
                    w_uns       = req_unsigned;
                    w_off       = req_addr[1:0];
                    w_wdata     = req_wdata[15:0];
                    if (w_misaligned) begin
                        w_state     = c_ST_RSP;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = '0;
                    end else if (req_we && req_size == 2'b10) begin
                        w_ram_addr = req_addr[ADDR_WIDTH+1:2];
                        w_ram_din  = req_wdata;
                        w_ram_we   = 1'b1;
                        w_state    = c_ST_WR;
                    end else begin
                        w_ram_addr  = req_addr[ADDR_WIDTH+1:2];
                        w_ram_regce = 1'b1;
                        w_cnt       = c_CNT_W'(READ_LATENCY);
                        w_state     = c_ST_RD;
                    end
                end
            end
            c_ST_RD: begin
                if (r_cnt == c_CNT_W'(1)) begin
                    w_cnt = '0;
                    if (r_we) begin
                        w_ram_din = w_merged;
                        w_ram_we  = 1'b1;
                        w_state   = c_ST_WR;
                    end else begin
                        w_rsp_rdata = w_load_data;
                        w_rsp_err   = 1'b0;
                        w_rsp_valid = 1'b1;
                        w_state     = c_ST_RSP;
                    end
                end else begin
                    w_cnt       = r_cnt - 1'b1;
                    w_ram_regce = 1'b1;
                end
            end
            c_ST_WR: begin
                w_rsp_valid = 1'b1;
                w_rsp_err   = 1'b0;
                w_rsp_rdata = '0;
                w_state     = c_ST_RSP;
            end
            default: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                    w_state     = c_ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_uns     <= 1'b0;
            r_off     <= 2'b00;
            r_wdata   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            ram_we    <= 1'b0;
            ram_regce <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_we      <= w_we;
            r_size    <= w_size;
            r_uns     <= w_uns;
            r_off     <= w_off;
            r_wdata   <= w_wdata;
            req_ready <= w_req_ready;
            rsp_valid <= w_rsp_valid;
            rsp_rdata <= w_rsp_rdata;
            rsp_err   <= w_rsp_err;
            ram_addr  <= w_ram_addr;
            ram_din   <= w_ram_din;
            ram_we    <= w_ram_we;
            ram_regce <= w_ram_regce;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit at READ_LATENCY 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid, req_we, req_unsigned, rsp_ready;
    logic [1:0]  req_size;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;

    logic [1:0]  d_req_ready, d_rsp_valid, d_rsp_err, d_ram_we, d_ram_regce;
    logic [31:0] d_rsp_rdata [2];
    logic [31:0] d_ram_din   [2];
    logic [31:0] d_ram_dout  [2];
    logic [9:0]  d_ram_addr  [2];
    int          we_cnt      [2] = '{0, 0};

    logic        w_ready, w_valid, w_err, w_we, w_regce;
    logic [31:0] w_rdata, w_din;
    logic [9:0]  w_raddr;

    logic [31:0] mdl [2][1024];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [1024];
        logic [31:0] dout_q;

        initial for (int i = 0; i < 1024; i++) mem[i] <= '0;

        mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(g + 1)) u_dut (
            .clka        (clk),
            .rsta        (rst),
            .req_valid   (req_valid && (sel == 1'(g))),
            .req_ready   (d_req_ready[g]),
            .req_we      (req_we),
            .req_size    (req_size),
            .req_unsigned(req_unsigned),
            .req_addr    (req_addr),
            .req_wdata   (req_wdata),
            .rsp_valid   (d_rsp_valid[g]),
            .rsp_ready   (rsp_ready && (sel == 1'(g))),
            .rsp_rdata   (d_rsp_rdata[g]),
            .rsp_err     (d_rsp_err[g]),
            .ram_addr    (d_ram_addr[g]),
            .ram_din     (d_ram_din[g]),
            .ram_we      (d_ram_we[g]),
            .ram_regce   (d_ram_regce[g]),
            .ram_dout    (d_ram_dout[g])
        );

        // RAM model: latency 1 reads straight through, latency 2 adds the output register
        always @(posedge clk) begin
            if (d_ram_we[g]) mem[d_ram_addr[g]] <= d_ram_din[g];
            if (d_ram_regce[g]) dout_q <= mem[d_ram_addr[g]];
        end
        if (g == 0) begin : g_lat1
            assign d_ram_dout[g] = mem[d_ram_addr[g]];
        end else begin : g_lat2
            assign d_ram_dout[g] = dout_q;
        end
    end

    always @(posedge clk) begin
        if (d_ram_we[0]) we_cnt[0] <= we_cnt[0] + 1;
        if (d_ram_we[1]) we_cnt[1] <= we_cnt[1] + 1;
    end

    assign w_ready = d_req_ready[sel];
    assign w_valid = d_rsp_valid[sel];
    assign w_err   = d_rsp_err[sel];
    assign w_we    = d_ram_we[sel];
    assign w_regce = d_ram_regce[sel];
    assign w_rdata = d_rsp_rdata[sel];
    assign w_din   = d_ram_din[sel];
    assign w_raddr = d_ram_addr[sel];

    // ---------------- reference model ----------------
    function automatic bit ref_misal(input logic [1:0] size, input logic [11:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns, input logic [1:0] off);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (word >> (8 * (3 - int'(off)))) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (word >> (16 * (1 - int'(off[1])))) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic [31:0] wdata);
        logic [31:0] mask;
        int          sh;
        if (size == 2'd0) begin
            sh   = 8 * (3 - int'(off));
            mask = 32'hFF << sh;
        end else if (size == 2'd1) begin
            sh   = 16 * (1 - int'(off[1]));
            mask = 32'hFFFF << sh;
        end else begin
            sh   = 0;
            mask = 32'hFFFF_FFFF;
        end
        return (word & ~mask) | ((wdata << sh) & mask);
    endfunction

    function automatic int ref_lat(input logic we, input logic [1:0] size, input logic [11:0] addr);
        if (ref_misal(size, addr)) return 0;
        if (we && size == 2'd2)    return 1;
        if (!we)                   return int'(sel) + 1;
        return int'(sel) + 2;
    endfunction

    task automatic mdl_apply(input logic we, input logic [1:0] size, input logic [11:0] addr,
                             input logic [31:0] wdata);
        if (we && !ref_misal(size, addr))
            mdl[sel][addr[11:2]] = ref_store(mdl[sel][addr[11:2]], size, addr[1:0], wdata);
    endtask

    // ---------------- driver ----------------
    task automatic wait_ready();
        int w = 0;
        while (!w_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        n_tests++;
        if (!w_ready) begin
            n_fail++;
            $display("FAIL req_ready_timeout got %b required 1", w_ready);
        end
    endtask

    task automatic present(input logic we, input logic [1:0] size, input logic uns,
                           input logic [11:0] addr, input logic [31:0] wdata);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = 12'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int pulses);
        int start;
        wait_ready();
        start = we_cnt[sel];
        present(we, size, uns, addr, wdata);
        lat = 0;
        while (!w_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rdata = w_rdata;
        err   = w_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        pulses = we_cnt[sel] - start;
        n_tests++;
        if (w_valid !== 1'b0 || w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_handshake valid/ready got %b%b required 01", w_valid, w_ready);
        end
        mdl_apply(we, size, addr, wdata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_tests++;
        if ({w_ready, w_valid, w_err, w_we, w_regce} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b required 00000", {w_ready, w_valid, w_err, w_we, w_regce});
        end
        n_tests++;
        if (w_rdata !== 32'h0 || w_din !== 32'h0 || w_raddr !== 10'h0) begin
            n_fail++;
            $display("FAIL reset_data rdata %h din %h addr %h required 0", w_rdata, w_din, w_raddr);
        end
        @(posedge clk); #1;
        n_tests++;
        if (w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_ready got %b required 0", w_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b required 1", w_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat, pul;
        do_req(1'b1, 2'd2, 1'b0, 12'h008, 32'hDEADBEEF, rd, er, lat, pul);
        n_tests++;
        if (er !== 1'b0 || lat != 1 || pul != 1) begin
            n_fail++;
            $display("FAIL sw_word err %b lat %0d pulses %0d required 0 1 1", er, lat, pul);
        end
        do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0, rd, er, lat, pul);
        n_tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != int'(sel) + 1) begin
            n_fail++;
            $display("FAIL lw_word rdata %h err %b lat %0d required DEADBEEF 0 %0d", rd, er, lat, int'(sel) + 1);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic er; int lat, pul;
        logic [11:0] a   [4] = '{12'h010, 12'h010, 12'h012, 12'h010};
        logic [1:0]  sz  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF};
        do_req(1'b1, 2'd2, 1'b0, 12'h010, 32'h80FF7F01, rd, er, lat, pul);
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], un[i], a[i], 32'h0, rd, er, lat, pul);
            n_tests++;
            if (rd !== exp[i] || er !== 1'b0 || lat != int'(sel) + 1) begin
                n_fail++;
                $display("FAIL lane_load%0d rdata %h err %b lat %0d required %h 0 %0d",
                         i, rd, er, lat, exp[i], int'(sel) + 1);
            end
        end
    endtask

    task automatic test_rmw();
        logic [31:0] rd; logic er; int lat, pul;
        do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'h11223344, rd, er, lat, pul);
        do_req(1'b1, 2'd0, 1'b0, 12'h021, 32'h000000AA, rd, er, lat, pul);
        n_tests++;
        if (pul != 1 || er !== 1'b0 || rd !== 32'h0 || lat != int'(sel) + 2) begin
            n_fail++;
            $display("FAIL rmw_sb pulses %0d err %b rdata %h lat %0d required 1 0 0 %0d", pul, er, rd, lat, int'(sel) + 2);
        end
        do_req(1'b1, 2'd1, 1'b0, 12'h022, 32'h0000BEEF, rd, er, lat, pul);
        n_tests++;
        if (pul != 1 || er !== 1'b0 || lat != int'(sel) + 2) begin
            n_fail++;
            $display("FAIL rmw_sh pulses %0d err %b lat %0d required 1 0 %0d", pul, er, lat, int'(sel) + 2);
        end
        do_req(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, rd, er, lat, pul);
        n_tests++;
        if (rd !== 32'h11AABEEF) begin
            n_fail++;
            $display("FAIL rmw_lw rdata %h required 11AABEEF", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat, pul;
        logic        we [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
        logic [11:0] a  [3] = '{12'h006, 12'h003, 12'h008};
        for (int i = 0; i < 3; i++) begin
            do_req(we[i], sz[i], 1'b0, a[i], 32'h12345678, rd, er, lat, pul);
            n_tests++;
            if (er !== 1'b1 || rd !== 32'h0 || pul != 0 || lat != 0) begin
                n_fail++;
                $display("FAIL misalign%0d err %b rdata %h pulses %0d lat %0d required 1 0 0 0", i, er, rd, pul, lat);
            end
        end
        do_req(1'b0, 2'd2, 1'b0, 12'h000, 32'h0, rd, er, lat, pul);
        n_tests++;
        if (rd !== mdl[sel][0]) begin
            n_fail++;
            $display("FAIL misalign_mem0 rdata %h required %h", rd, mdl[sel][0]);
        end
        do_req(1'b0, 2'd2, 1'b0, 12'h008, 32'h0, rd, er, lat, pul);
        n_tests++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL misalign_mem8 rdata %h required DEADBEEF", rd);
        end
    endtask

    task automatic test_backpressure();
        int w = 0;
        wait_ready();
        present(1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
        n_tests++;
        if (w_regce !== 1'b1 || w_we !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_regce regce %b we %b required 1 0", w_regce, w_we);
        end
        while (!w_valid && w < 20) begin
            @(posedge clk); #1; w++;
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if (w_valid !== 1'b1 || w_rdata !== 32'h11AABEEF || w_err !== 1'b0 || w_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d valid %b rdata %h err %b ready %b required 1 11AABEEF 0 0",
                         c, w_valid, w_rdata, w_err, w_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_tests++;
        if (w_valid !== 1'b0 || w_ready !== 1'b1 || w_regce !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release valid %b ready %b regce %b required 0 1 0", w_valid, w_ready, w_regce);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat, pul;
        do_req(1'b1, 2'd2, 1'b0, 12'h030, 32'h12345678, rd, er, lat, pul);
        wait_ready();
        present(1'b1, 2'd0, 1'b0, 12'h031, 32'h00000055);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({w_we, w_regce, w_valid, w_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_rd_ctrl got %b required 0000", {w_we, w_regce, w_valid, w_ready});
        end
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rd_ready got %b required 1", w_ready);
        end
        do_req(1'b0, 2'd2, 1'b0, 12'h030, 32'h0, rd, er, lat, pul);
        n_tests++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL rst_rd_intact rdata %h required 12345678", rd);
        end
        // Abort a word store while its write strobe is up
        present(1'b1, 2'd2, 1'b0, 12'h040, 32'hA5A5A5A5);
        n_tests++;
        if (w_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wr_we_before got %b required 1", w_we);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (w_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wr_we_drop got %b required 0", w_we);
        end
        @(negedge clk); rst = 1'b0;
        do_req(1'b0, 2'd2, 1'b0, 12'h040, 32'h0, rd, er, lat, pul);
        n_tests++;
        if (rd !== mdl[sel][12'h040 >> 2]) begin
            n_fail++;
            $display("FAIL rst_wr_intact rdata %h required %h", rd, mdl[sel][12'h040 >> 2]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, wd, exp_rd; logic er, we, un, exp_er; int lat, pul, exp_pul, exp_lat;
        logic [1:0]  sz;
        logic [9:0]  word;
        logic [11:0] a;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       word = 10'd0;
                1:       word = 10'h3FF;
                2:       word = 10'($urandom_range(0, 15));
                default: word = 10'($urandom);
            endcase
            a  = {word, ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom)};
            sz = 2'($urandom);
            we = 1'($urandom);
            un = 1'($urandom);
            wd = $urandom;
            exp_er  = ref_misal(sz, a);
            exp_rd  = (we || exp_er) ? 32'h0 : ref_load(mdl[sel][a[11:2]], sz, un, a[1:0]);
            exp_pul = (we && !exp_er) ? 1 : 0;
            exp_lat = ref_lat(we, sz, a);
            do_req(we, sz, un, a, wd, rd, er, lat, pul);
            n_tests++;
            if (rd !== exp_rd || er !== exp_er) begin
                n_fail++;
                $display("FAIL rand%0d we %b size %0d addr %h rdata %h err %b required %h %b",
                         i, we, sz, a, rd, er, exp_rd, exp_er);
            end
            n_tests++;
            if (lat != exp_lat || pul != exp_pul) begin
                n_fail++;
                $display("FAIL rand%0d_timing lat %0d pulses %0d required %0d %0d", i, lat, pul, exp_lat, exp_pul);
            end
        end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            mdl[0][i] = '0;
            mdl[1][i] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            sel = 1'(p);
            test_reset();
            test_word();
            test_lanes();
            test_rmw();
            test_misalign();
            test_backpressure();
            test_reset_mid();
            test_random();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
